// File: rtl/dnn_sample_feeder.sv
// dnn_sample_feeder: double-buffered training-sample source for the DNN core.
// Takes a header beat plus n_in*width_in/beat_width activation beats per
// sample from a ready/valid stream. One bank presents its sample slice by
// slice, in step with the core's cycle_index, while the other bank fills.
module dnn_sample_feeder #(
  parameter int width_in     = 8,
  parameter int n_in         = 1024,
  parameter int n_out        = 16,
  parameter int act_per_clk  = 64,
  parameter int cpc          = 18,
  parameter int etapos_width = 4,
  parameter int beat_width   = 64,
  parameter int etapos_skip  = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [beat_width-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [$clog2(cpc)-1:0]          cycle_index,
  output logic [width_in*act_per_clk-1:0] act0,
  output logic                            ans0,
  output logic [etapos_width-1:0]         etapos0,
  output logic                            sample_valid,
  output logic [15:0]                     samples_issued,
  output logic [15:0]                     underflow_count
);

  localparam int LBLW            = $clog2(n_out);
  localparam int SLICE_W         = width_in * act_per_clk;
  localparam int N_SLICES        = n_in / act_per_clk;
  localparam int DATA_BEATS      = n_in * width_in / beat_width;
  localparam int BEATS_PER_SLICE = SLICE_W / beat_width;
  localparam int SUBW            = $clog2(BEATS_PER_SLICE);
  localparam int SLW             = $clog2(N_SLICES);
  localparam int CNT_W           = $clog2(DATA_BEATS);

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_WAIT
  } fill_state_t;

  fill_state_t state, state_nxt;

  // Activation store: per bank, one act0-wide word per slice. Beats land
  // in consecutive beat_width lanes, so the lowest activation is in the LSBs.
  logic [SLICE_W-1:0]      mem [2][N_SLICES];
  logic [LBLW-1:0]         label_q  [2];
  logic [etapos_width-1:0] etapos_q [2];
  logic [1:0]              full_q;
  logic                    act_sel;
  logic                    fill_sel;
  logic [CNT_W-1:0]        beat_cnt;

  logic [31:0] ci_ext;
  logic        boundary;
  logic        swap;
  logic        accept;

  assign ci_ext   = 32'(cycle_index);
  assign fill_sel = ~act_sel;
  assign boundary = (ci_ext == 32'(cpc - 1));
  // Swap decision uses the pre-edge full flag, so a sample completing on
  // the boundary edge itself waits for the next boundary.
  assign swap     = boundary && full_q[fill_sel];
  assign in_ready = (state != S_WAIT);
  assign accept   = in_valid && in_ready;

  // Fill FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill FSM next state: header, data beats, then hold until the swap frees a bank.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (accept) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (accept && (beat_cnt == CNT_W'(DATA_BEATS - 1))) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (swap) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  // Bank control, header capture, beat counter and the two status counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_sel         <= 1'b0;
      full_q          <= '0;
      beat_cnt        <= '0;
      label_q         <= '{default: '0};
      etapos_q        <= '{default: '0};
      sample_valid    <= 1'b0;
      samples_issued  <= '0;
      underflow_count <= '0;
    end else begin
      if (swap) begin
        act_sel         <= ~act_sel;
        full_q[act_sel] <= 1'b0;
        sample_valid    <= 1'b1;
        samples_issued  <= samples_issued + 16'd1;
      end else if (boundary) begin
        sample_valid <= 1'b0;
        if (underflow_count != '1) underflow_count <= underflow_count + 16'd1;
      end

      if (accept) begin
        if (state == S_HDR) begin
          label_q[fill_sel]  <= in_data[LBLW-1:0];
          etapos_q[fill_sel] <= in_data[LBLW +: etapos_width];
        end else if (beat_cnt == CNT_W'(DATA_BEATS - 1)) begin
          beat_cnt         <= '0;
          full_q[fill_sel] <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Activation store write; contents need no reset because they are only
  // visible through a bank whose sample has been fully reloaded.
  always_ff @(posedge clk) begin
    if (accept && (state == S_DATA)) begin
      mem[fill_sel][beat_cnt[CNT_W-1:SUBW]][beat_cnt[SUBW-1:0]*beat_width +: beat_width] <= in_data;
    end
  end

  // Core-facing outputs, combinational from the active bank and cycle_index.
  always_comb begin
    act0    = '0;
    ans0    = 1'b0;
    etapos0 = etapos_width'(etapos_skip);
    if (sample_valid) begin
      etapos0 = etapos_q[act_sel];
      if (ci_ext < 32'(N_SLICES)) act0 = mem[act_sel][cycle_index[SLW-1:0]];
      ans0 = (ci_ext < 32'(n_out)) && (32'(label_q[act_sel]) == ci_ext);
    end
  end

endmodule

// File: tb/tb_dnn_sample_feeder.sv
// Bench for dnn_sample_feeder: directed scenario sequence with $urandom
// content and gaps, checked every cycle against a sample-level model.
module tb_dnn_sample_feeder;

  localparam int CPC   = 18;
  localparam int NIN   = 1024;
  localparam int BEATS = 129;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   cycle_index;
  logic [511:0] act0;
  logic         ans0;
  logic [3:0]   etapos0;
  logic         sample_valid;
  logic [15:0]  samples_issued;
  logic [15:0]  underflow_count;

  always #5 clk = ~clk;

  dnn_sample_feeder #(
    .width_in(8), .n_in(1024), .n_out(16), .act_per_clk(64), .cpc(18),
    .etapos_width(4), .beat_width(64), .etapos_skip(0)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cycle_index(cycle_index), .act0(act0), .ans0(ans0),
    .etapos0(etapos0), .sample_valid(sample_valid),
    .samples_issued(samples_issued), .underflow_count(underflow_count)
  );

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  // Sample-level model: a filling sample (beats received so far) and a presented one.
  bit           m_fill_full;
  int           m_cnt;
  bit [3:0]     m_fill_label, m_fill_eta;
  byte unsigned m_fill_act [NIN];
  bit           m_valid;
  bit [3:0]     m_label, m_eta;
  byte unsigned m_act [NIN];
  int           m_issued, m_under;
  bit           m_acc;

  int           ci;
  bit           ci_run;
  byte unsigned tx_act [NIN];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    nchk++;
    nfail++;
    $error("FAIL %s: no progress within cycle bound", tag);
  endtask

  task automatic model_reset();
    m_fill_full = 1'b0; m_cnt = 0; m_valid = 1'b0;
    m_label = '0; m_eta = '0; m_issued = 0; m_under = 0; m_acc = 1'b0;
  endtask

  // Apply one rising edge to the model using the pre-edge inputs.
  task automatic model_edge();
    m_acc = (in_valid === 1'b1) && !m_fill_full;
    if (cycle_index == 5'd17) begin
      if (m_fill_full) begin
        m_act       = m_fill_act;
        m_label     = m_fill_label;
        m_eta       = m_fill_eta;
        m_valid     = 1'b1;
        m_issued    = (m_issued + 1) % 65536;
        m_fill_full = 1'b0;
      end else begin
        m_valid = 1'b0;
        if (m_under < 65535) m_under++;
      end
    end
    if (m_acc) begin
      if (m_cnt == 0) begin
        m_fill_label = in_data[3:0];
        m_fill_eta   = in_data[7:4];
      end else begin
        for (int b = 0; b < 8; b++) m_fill_act[8*(m_cnt-1)+b] = in_data[8*b +: 8];
      end
      m_cnt++;
      if (m_cnt == BEATS) begin
        m_fill_full = 1'b1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [511:0] e_act;
    logic         e_ans;
    e_act = '0;
    if (m_valid && ci < 16)
      for (int j = 0; j < 64; j++) e_act[8*j +: 8] = m_act[ci*64+j];
    e_ans = m_valid && (ci < 16) && (int'(m_label) == ci);
    chk("in_ready", 512'(in_ready), 512'(!m_fill_full));
    chk("sample_valid", 512'(sample_valid), 512'(m_valid));
    chk("act0", act0, e_act);
    chk("ans0", 512'(ans0), 512'(e_ans));
    chk("etapos0", 512'(etapos0), 512'(m_valid ? m_eta : 4'd0));
    chk("samples_issued", 512'(samples_issued), 512'(m_issued));
    chk("underflow_count", 512'(underflow_count), 512'(m_under));
  endtask

  task automatic set_ci(input int v);
    ci = v;
    cycle_index = 5'(v);
  endtask

  // One clock: check outputs, clock the model, then move cycle_index on.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (ci_run) set_ci((ci + 1) % CPC);
  endtask

  function automatic logic [63:0] act_beat(input int k);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[8*b +: 8] = tx_act[8*(k-1)+b];
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] d, input int gap_pct);
    int guard;
    guard = 0;
    in_data = d;
    do begin
      in_valid = ($urandom_range(99) >= gap_pct);
      tick();
      guard++;
    end while (!m_acc && guard < 2000);
    if (!m_acc) bound_fail("send_beat");
  endtask

  task automatic send_sample(input logic [3:0] lbl, input logic [3:0] eta,
                             input int gap_pct, input int nbeats);
    logic [63:0] hdr;
    hdr = {$urandom(), $urandom()};
    hdr[7:0] = {eta, lbl};
    send_beat(hdr, gap_pct);
    for (int k = 1; k < nbeats; k++) send_beat(act_beat(k), gap_pct);
    in_valid = 1'b0;
  endtask

  task automatic fill_plain();
    for (int i = 0; i < NIN; i++) tx_act[i] = 8'(i % 256);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NIN; i++) tx_act[i] = 8'($urandom);
  endtask

  task automatic wait_issue(input int base);
    int g;
    g = 0;
    while (m_issued == base && g < 300) begin
      tick();
      g++;
    end
    if (m_issued == base) bound_fail("wait_issue");
  endtask

  // Label 5, etapos 3, activation i = i mod 256, starting at cycle_index 0.
  task automatic check_plain_sample(input string tag);
    for (int c = 0; c < CPC; c++) begin
      #1;
      chk({tag, "_valid"}, 512'(sample_valid), 512'(1'b1));
      chk({tag, "_etapos"}, 512'(etapos0), 512'(4'd3));
      if (c == 5) chk({tag, "_ans_at_5"}, 512'(ans0), 512'(1'b1));
      if (c == 2) chk({tag, "_slice2_byte0"}, 512'(act0[7:0]), 512'(8'd128));
      if (c >= 16) chk({tag, "_act_zero_tail"}, act0, '0);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time budget exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_iss, base_und;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; ci_run = 1'b0;
    set_ci(0);
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Idle for three block cycles.
    ci_run = 1'b1;
    repeat (3 * CPC) tick();
    #1;
    chk("idle_underflow3", 512'(underflow_count), 512'(16'd3));
    chk("idle_valid", 512'(sample_valid), 512'(1'b0));
    chk("idle_act0", act0, '0);
    chk("idle_etapos", 512'(etapos0), 512'(4'd0));
    chk("idle_ready", 512'(in_ready), 512'(1'b1));

    // First sample, in_valid held high.
    fill_plain();
    base_iss = m_issued;
    send_sample(4'd5, 4'd3, 0, BEATS);
    #1;
    chk("ready_drop", 512'(in_ready), 512'(1'b0));
    wait_issue(base_iss);
    check_plain_sample("gapless");

    // Two samples preloaded with the core counter held, then run back to back.
    ci_run = 1'b0;
    set_ci(0);
    base_iss = m_issued;
    base_und = m_under;
    fill_rand();
    send_sample(4'd0, 4'($urandom), 0, BEATS);
    set_ci(17);
    tick();
    set_ci(0);
    fill_rand();
    send_sample(4'd15, 4'($urandom), 0, BEATS);
    ci_run = 1'b1;
    for (int c = 0; c < CPC; c++) begin
      #1;
      chk("b2b_A_valid", 512'(sample_valid), 512'(1'b1));
      if (c == 0) chk("b2b_A_ans_at_0", 512'(ans0), 512'(1'b1));
      tick();
    end
    for (int c = 0; c < CPC; c++) begin
      #1;
      chk("b2b_B_valid", 512'(sample_valid), 512'(1'b1));
      if (c == 15) chk("b2b_B_ans_at_15", 512'(ans0), 512'(1'b1));
      if (c == 17) begin
        chk("b2b_issued", 512'(samples_issued), 512'((base_iss + 2) % 65536));
        chk("b2b_no_underflow", 512'(underflow_count), 512'(base_und));
      end
      tick();
    end

    // Last beat accepted on the boundary edge.
    ci_run = 1'b0;
    base_iss = m_issued;
    base_und = m_under;
    fill_rand();
    send_sample(4'd7, 4'($urandom), 0, BEATS - 1);
    set_ci(17);
    in_data = act_beat(BEATS - 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_ci(0);
    #1;
    chk("edge_last_ready", 512'(in_ready), 512'(1'b0));
    chk("edge_last_no_swap", 512'(sample_valid), 512'(1'b0));
    chk("edge_last_underflow", 512'(underflow_count), 512'((base_und + 1) % 65536));
    chk("edge_last_issued", 512'(samples_issued), 512'(base_iss));
    ci_run = 1'b1;
    repeat (CPC) tick();
    #1;
    chk("edge_next_valid", 512'(sample_valid), 512'(1'b1));
    chk("edge_next_issued", 512'(samples_issued), 512'((base_iss + 1) % 65536));
    for (int c = 0; c < CPC; c++) begin
      #1;
      if (c == 7) chk("edge_ans_at_7", 512'(ans0), 512'(1'b1));
      tick();
    end

    // 50% in_valid gaps: same plain sample, then random content.
    fill_plain();
    base_iss = m_issued;
    send_sample(4'd5, 4'd3, 50, BEATS);
    wait_issue(base_iss);
    check_plain_sample("gapped");
    fill_rand();
    base_iss = m_issued;
    send_sample(4'($urandom), 4'($urandom), 50, BEATS);
    wait_issue(base_iss);
    repeat (CPC) tick();

    // Reset while a sample is presented and the next is mid-DATA.
    ci_run = 1'b0;
    set_ci(0);
    fill_rand();
    send_sample(4'd9, 4'd6, 0, BEATS);
    set_ci(17);
    tick();
    set_ci(9);
    fill_rand();
    send_sample(4'd2, 4'd1, 0, 60);
    #1;
    chk("pre_reset_valid", 512'(sample_valid), 512'(1'b1));
    chk("pre_reset_ans", 512'(ans0), 512'(1'b1));
    chk("pre_reset_etapos", 512'(etapos0), 512'(4'd6));
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", 512'(in_ready), 512'(1'b1));
    chk("rst_valid", 512'(sample_valid), 512'(1'b0));
    chk("rst_act0", act0, '0);
    chk("rst_ans0", 512'(ans0), 512'(1'b0));
    chk("rst_etapos", 512'(etapos0), 512'(4'd0));
    chk("rst_issued", 512'(samples_issued), 512'(16'd0));
    chk("rst_underflow", 512'(underflow_count), 512'(16'd0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fill_rand();
    send_sample(4'd12, 4'd10, 0, BEATS);
    set_ci(17);
    tick();
    set_ci(0);
    ci_run = 1'b1;
    for (int c = 0; c < CPC; c++) begin
      #1;
      if (c == 0) begin
        chk("post_rst_issued", 512'(samples_issued), 512'(16'd1));
        chk("post_rst_underflow", 512'(underflow_count), 512'(16'd0));
        chk("post_rst_etapos", 512'(etapos0), 512'(4'd10));
      end
      if (c == 12) chk("post_rst_ans_at_12", 512'(ans0), 512'(1'b1));
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
